// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for a 5-stage (F, D, E, M, W) pipeline.
// Produces stall/flush controls, E-stage forwarding selects, a memory-wait
// FSM with a sticky timeout error, and saturating stall/flush counters.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic             Load_E,
  input  logic             PCSrc_E,
  input  logic [4:0]       Rd_M,
  input  logic             RegWrite_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_W,
  input  logic             MemReq_M,
  input  logic             MemReady_M,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic             Stall_E,
  output logic             Flush_E,
  output logic             Stall_M,
  output logic             Flush_W,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic [1:0]       State,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_t;

  localparam logic [7:0]       TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [7:0]       waitCnt_q, waitCnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stallCount_q, stallCount_d;
  logic [CNT_W-1:0] flushCount_q, flushCount_d;

  logic loadUse;
  logic memWait;
  logic runStallFD, runFlushD, runFlushE;
  logic freeze, useRun;

  // M-stage result beats W-stage result; x0 is never forwarded.
  function automatic logic [1:0] fwdSel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == rs))
      sel = 2'b10;
    else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == rs))
      sel = 2'b01;
    return sel;
  endfunction

  // Forwarding selects are independent of the FSM state.
  always_comb begin
    ForwardA_E = fwdSel(Rs1_E);
    ForwardB_E = fwdSel(Rs2_E);
  end

  // Raw hazard events and the controls the RUN state would apply; a taken
  // branch discards the dependent instruction, so it suppresses the bubble.
  always_comb begin
    loadUse    = Load_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    memWait    = MemReq_M && !MemReady_M;
    runFlushD  = PCSrc_E;
    runFlushE  = PCSrc_E || loadUse;
    runStallFD = !PCSrc_E && loadUse;
  end

  // Next-state logic and Mealy stall/flush outputs for the memory-wait FSM.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    timeout_d = timeout_q;
    freeze    = 1'b0;
    useRun    = 1'b0;

    case (state_q)
      RUN: begin
        if (memWait) begin
          freeze    = 1'b1;
          state_d   = MEM_WAIT;
          waitCnt_d = 8'd1;
        end else begin
          useRun = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MemReady_M) begin
          useRun    = 1'b1;
          state_d   = RUN;
          waitCnt_d = 8'd0;
        end else begin
          freeze    = 1'b1;
          waitCnt_d = waitCnt_q + 8'd1;
          if (waitCnt_d >= TIMEOUT_CNT) begin
            state_d   = ERR;
            timeout_d = 1'b1;
          end
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d   = RUN;
        waitCnt_d = 8'd0;
      end
    endcase

    Stall_F = freeze || (useRun && runStallFD);
    Stall_D = freeze || (useRun && runStallFD);
    Stall_E = freeze;
    Stall_M = freeze;
    Flush_W = freeze;
    Flush_D = useRun && runFlushD;
    Flush_E = useRun && runFlushE;

    if (reset) begin
      Stall_F = 1'b0;
      Stall_D = 1'b0;
      Stall_E = 1'b0;
      Stall_M = 1'b0;
      Flush_W = 1'b0;
      Flush_D = 1'b0;
      Flush_E = 1'b0;
    end
  end

  // Saturating performance counters driven by the final stall/flush outputs.
  always_comb begin
    stallCount_d = stallCount_q;
    flushCount_d = flushCount_q;
    if (Stall_F && (stallCount_q != CNT_MAX))
      stallCount_d = stallCount_q + 1'b1;
    if (Flush_D && (flushCount_q != CNT_MAX))
      flushCount_d = flushCount_q + 1'b1;
  end

  // State, wait counter, sticky timeout and counters; reset wins from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      waitCnt_q    <= 8'd0;
      timeout_q    <= 1'b0;
      stallCount_q <= '0;
      flushCount_q <= '0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      timeout_q    <= timeout_d;
      stallCount_q <= stallCount_d;
      flushCount_q <= flushCount_d;
    end
  end

  assign State      = state_q;
  assign MemTimeout = timeout_q;
  assign StallCount = stallCount_q;
  assign FlushCount = flushCount_q;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard and sequencing controller for the 5-stage pipeline (F, D, E, M, W).
- Detects load-use hazards, taken branches/jumps and data-memory wait states.
- Drives stall/flush for the F/D/E/M pipeline registers and forwarding selects for the E-stage ALU operands.
- Keeps a small FSM for memory-wait sequencing with a timeout, plus saturating performance counters.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before the sticky timeout error is raised (range 2..255).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Rs1_D  in  5  rs1 of the instruction in D.
- Rs2_D  in  5  rs2 of the instruction in D.
- Rs1_E  in  5  rs1 of the instruction in E.
- Rs2_E  in  5  rs2 of the instruction in E.
- Rd_E  in  5  rd of the instruction in E.
- Load_E  in  1  instruction in E is a load (opcode 0000011).
- PCSrc_E  in  1  branch taken or jump in E.
- Rd_M  in  5  rd in M.
- RegWrite_M  in  1  M-stage instruction writes the register file.
- Rd_W  in  5  rd in W.
- RegWrite_W  in  1  W-stage instruction writes the register file.
- MemReq_M  in  1  M-stage load/store is active this cycle.
- MemReady_M  in  1  data memory completes the access this cycle.
- Stall_F  out  1  hold PC.
- Stall_D  out  1  hold the F/D register.
- Flush_D  out  1  clear the F/D register to a NOP.
- Stall_E  out  1  hold the D/E register.
- Flush_E  out  1  clear the D/E register to a bubble.
- Stall_M  out  1  hold the E/M register.
- Flush_W  out  1  clear the M/W register to a bubble.
- ForwardA_E  out  2  operand A select: 00 register file, 10 M-stage result, 01 W-stage result.
- ForwardB_E  out  2  operand B select, same encoding as ForwardA_E.
- State  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 ERR.
- MemTimeout  out  1  sticky timeout error flag.
- StallCount  out  CNT_W  count of stall cycles, saturating.
- FlushCount  out  CNT_W  count of flush events, saturating.

Behaviour:
- Reset (synchronous): State=RUN, MemTimeout=0, StallCount=0, FlushCount=0, wait counter=0. While reset is asserted, all stall and flush outputs are 0.
- All stall, flush and forward outputs are combinational (Mealy) from the current state and inputs. State and counters update on the rising clk edge.

Forwarding (E stage), evaluated independently in every state:
- ForwardA_E=10 if RegWrite_M and Rd_M!=0 and Rd_M==Rs1_E.
- Otherwise ForwardA_E=01 if RegWrite_W and Rd_W!=0 and Rd_W==Rs1_E.
- Otherwise ForwardA_E=00.
- M has priority over W. ForwardB_E uses Rs2_E with the same rules.

Events:
- lu = Load_E and Rd_E!=0 and (Rd_E==Rs1_D or Rd_E==Rs2_D).
- mw = MemReq_M and not MemReady_M.

RUN state, priority mw > PCSrc_E > lu:
- mw: Stall_F, Stall_D, Stall_E and Stall_M=1; Flush_W=1. Next state MEM_WAIT, wait counter=1.
- PCSrc_E: Flush_D=1 and Flush_E=1; no stall.
- lu (no PCSrc_E): Stall_F=1, Stall_D=1, Flush_E=1. This is a single-cycle bubble; no state change.
- PCSrc_E and lu together: the flush wins and lu is ignored, because the dependent instruction is being discarded.

MEM_WAIT state:
- Stall_F, Stall_D, Stall_E and Stall_M=1; Flush_W=1; Flush_D and Flush_E=0. PCSrc_E and lu are ignored (frozen).
- MemReady_M=1: outputs are as in RUN for this cycle; next state RUN, wait counter cleared.
- Otherwise the wait counter increments. When it reaches MEM_TIMEOUT: next state ERR, MemTimeout=1.

ERR state:
- Same freeze outputs as MEM_WAIT.
- MemTimeout stays at 1 until reset; MemReady_M does not exit this state. Only reset exits.

Counters:
- StallCount increments in every cycle where Stall_F=1.
- FlushCount increments in every cycle where Flush_D=1.
- Both saturate at 2^CNT_W-1 and never wrap.

Reset mid-operation:
- Reset in MEM_WAIT or ERR returns to RUN on the same edge.
- Reset also clears MemTimeout and both counters.

Test Plan:
- Load-use: Load_E=1, Rd_E=5, Rs1_D=5 for 1 cycle -> Stall_F=Stall_D=Flush_E=1 that cycle only; StallCount 0->1; State stays 00.
- x0 and forwarding: Rd_E=0 with a load, Rs1_D=0 -> no stall. RegWrite_M=1, Rd_M=7, RegWrite_W=1, Rd_W=7, Rs2_E=7 -> ForwardB_E=10. With RegWrite_M=0 -> ForwardB_E=01.
- Branch with simultaneous load-use: PCSrc_E=1, Load_E=1, Rd_E=3, Rs2_D=3 -> Flush_D=Flush_E=1, Stall_F=0; FlushCount +1, StallCount unchanged.
- Memory wait: MemReq_M=1, MemReady_M=0 for 3 cycles, then MemReady_M=1 -> full stall and Flush_W=1 for 3 cycles; State 01 from cycle 2; RUN after the ready edge; StallCount +3.
- Timeout: MEM_TIMEOUT=4, MemReady_M held at 0 -> State=10 and MemTimeout=1 after 4 wait cycles; a later MemReady_M=1 keeps ERR; reset -> State=00, MemTimeout=0, counters=0.
- Saturation: CNT_W=4, continuous load-use stalls for 20 cycles -> StallCount holds at 15.
